// File: rtl/riscv_ctrl_fsm_pkg.sv
// ----------------------------------------------------------------------------
// riscv_ctrl_fsm_pkg
// Shared types for the multi-cycle RV32I control sequencer: decoder control
// field encodings, controller state enum and trap cause codes.
// ----------------------------------------------------------------------------
package riscv_ctrl_fsm_pkg;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_t;

    typedef enum logic {
        RF_NONE  = 1'b0,
        RF_WRITE = 1'b1
    } rf_wen_t;

    typedef enum logic {
        MEM_NONE  = 1'b0,
        MEM_WRITE = 1'b1
    } mem_wen_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'd0,
        PC_BRANCH = 2'd1,
        PC_JAL    = 2'd2,
        PC_JALR   = 2'd3
    } pc_sel_t;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } ctrl_state_t;

    localparam logic [1:0] TRAP_NONE    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
    localparam logic [1:0] TRAP_IMEM_TO = 2'd2;
    localparam logic [1:0] TRAP_DMEM_TO = 2'd3;

    // Loads and stores both need a data-memory phase.
    function automatic logic needs_mem(input wb_sel_t ws, input mem_wen_t mw);
        return (ws == WB_MEM) || (mw == MEM_WRITE);
    endfunction

endpackage

// File: rtl/riscv_ctrl_fsm_perf_counter.sv
// ----------------------------------------------------------------------------
// riscv_perf_counter
// Free-running event counter that wraps modulo 2^W and can be frozen.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_en          : count this cycle
//   i_freeze      : hold the count regardless of i_en
//   o_cnt         : current count
// ----------------------------------------------------------------------------
module riscv_perf_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_freeze,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en && !i_freeze) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/riscv_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// riscv_ctrl_fsm
// Multi-cycle control sequencer for the RV32I core. Steps each instruction
// through fetch / decode / execute / memory / writeback, drives IR, PC,
// register-file and data-memory enables, and raises a sticky trap on an
// illegal instruction or a memory handshake timeout.
//
// Optional feature macro: RISCV_CTRL_PERF_EN adds cycle and retired-
// instruction counters (o_cycle_cnt, o_instret_cnt).
//
// Ports:
//   i_clk, i_rst                 : clock, synchronous active-high reset
//   i_inst_valid                 : decoder recognised the instruction in IR
//   i_wb_sel/i_rf_wen/i_mem_wen  : decoder control fields
//   i_pc_sel                     : next-PC select (consumed by the PC datapath)
//   i_imem_ready, i_dmem_ready   : memory handshake completions
//   o_imem_req, o_dmem_req       : memory requests
//   o_dmem_we                    : data access is a store
//   o_ir_we, o_pc_we, o_rf_we    : datapath enables
//   o_retire                     : one pulse per completed instruction
//   o_trap, o_trap_cause         : sticky trap flag and cause
//   o_state                      : current state (debug)
//   o_cycle_cnt, o_instret_cnt   : perf counters (macro only)
//
// state    | meaning
// ---------+-----------------------------------------------
// S_FETCH  | request instruction, latch into IR on ready
// S_DECODE | one cycle, check decoder legality
// S_EXEC   | one ALU cycle, choose memory phase or writeback
// S_MEM    | data memory access until ready
// S_WB     | PC update, register write, retire
// S_TRAP   | absorbing error state, left only by reset
// ----------------------------------------------------------------------------
module riscv_ctrl_fsm
    import riscv_ctrl_fsm_pkg::*;
#(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_inst_valid,
    input  wb_sel_t     i_wb_sel,
    input  rf_wen_t     i_rf_wen,
    input  mem_wen_t    i_mem_wen,
    input  pc_sel_t     i_pc_sel,
    input  logic        i_imem_ready,
    input  logic        i_dmem_ready,
    output logic        o_imem_req,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic        o_ir_we,
    output logic        o_pc_we,
    output logic        o_rf_we,
    output logic        o_retire,
    output logic        o_trap,
    output logic [1:0]  o_trap_cause,
    output ctrl_state_t o_state
`ifdef RISCV_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0] o_cycle_cnt,
    output logic [CNT_W-1:0] o_instret_cnt
`endif
);

    localparam int WAIT_W = (MEM_TIMEOUT > 255) ? $clog2(MEM_TIMEOUT + 1) : 8;
    localparam logic [WAIT_W-1:0] TO_CMP = WAIT_W'(MEM_TIMEOUT);

    ctrl_state_t       r_state;
    ctrl_state_t       w_next;
    logic [1:0]        w_next_cause;
    logic [1:0]        r_cause;
    logic [WAIT_W-1:0] r_wait;
    logic              w_to_hit;
    logic              w_wait_cycle;

    // The PC datapath consumes i_pc_sel directly; the sequencer only gates pc_we.
    logic w_unused_pc_sel;
    assign w_unused_pc_sel = ^i_pc_sel;

    assign w_to_hit = (MEM_TIMEOUT != 0) && (r_wait == TO_CMP);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; ready is checked before the timeout so a late ready wins.
    always_comb begin
        w_next       = r_state;
        w_next_cause = TRAP_NONE;
        case (r_state)
            S_FETCH: begin
                if (i_imem_ready) begin
                    w_next = S_DECODE;
                end else if (w_to_hit) begin
                    w_next       = S_TRAP;
                    w_next_cause = TRAP_IMEM_TO;
                end
            end
            S_DECODE: begin
                if (i_inst_valid) begin
                    w_next = S_EXEC;
                end else begin
                    w_next       = S_TRAP;
                    w_next_cause = TRAP_ILLEGAL;
                end
            end
            S_EXEC: begin
                w_next = needs_mem(i_wb_sel, i_mem_wen) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (i_dmem_ready) begin
                    w_next = S_WB;
                end else if (w_to_hit) begin
                    w_next       = S_TRAP;
                    w_next_cause = TRAP_DMEM_TO;
                end
            end
            S_WB:    w_next = S_FETCH;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        o_imem_req = 1'b0;
        o_ir_we    = 1'b0;
        o_dmem_req = 1'b0;
        o_dmem_we  = 1'b0;
        o_pc_we    = 1'b0;
        o_rf_we    = 1'b0;
        o_retire   = 1'b0;
        o_trap     = 1'b0;
        case (r_state)
            S_FETCH: begin
                o_imem_req = 1'b1;
                o_ir_we    = i_imem_ready;
            end
            S_MEM: begin
                o_dmem_req = 1'b1;
                o_dmem_we  = (i_mem_wen == MEM_WRITE);
            end
            S_WB: begin
                o_pc_we  = 1'b1;
                o_retire = 1'b1;
                o_rf_we  = (i_rf_wen == RF_WRITE);
            end
            S_TRAP:  o_trap = 1'b1;
            default: ;
        endcase
    end

    assign w_wait_cycle = (o_imem_req && !i_imem_ready) ||
                          (o_dmem_req && !i_dmem_ready);

    // Wait counter restarts on entry to each handshake state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wait <= '0;
        end else if ((w_next != r_state) &&
                     ((w_next == S_FETCH) || (w_next == S_MEM))) begin
            r_wait <= '0;
        end else if (w_wait_cycle) begin
            r_wait <= r_wait + 1'b1;
        end
    end

    // Cause is captured once on trap entry and held until reset.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cause <= TRAP_NONE;
        end else if ((r_state != S_TRAP) && (w_next == S_TRAP)) begin
            r_cause <= w_next_cause;
        end
    end

    assign o_trap_cause = r_cause;
    assign o_state      = r_state;

`ifdef RISCV_CTRL_PERF_EN
    riscv_perf_counter #(.W(CNT_W)) u_cycle_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (1'b1),
        .i_freeze (o_trap),
        .o_cnt    (o_cycle_cnt)
    );

    riscv_perf_counter #(.W(CNT_W)) u_instret_cnt (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_en     (o_retire),
        .i_freeze (o_trap),
        .o_cnt    (o_instret_cnt)
    );
`else
    logic [CNT_W-1:0] w_unused_cnt;
    assign w_unused_cnt = '0;
`endif

endmodule

// File: tb/tb_riscv_ctrl_fsm.sv
// ----------------------------------------------------------------------------
// tb_riscv_ctrl_fsm
// Builds an expected per-cycle timeline for each instruction from its class
// and its memory wait counts, drives the matching stimulus, and checks every
// cycle. A few literal expectations pin the model (retire cycles, causes,
// counter values).
// ----------------------------------------------------------------------------
module tb_riscv_ctrl_fsm;
    import riscv_ctrl_fsm_pkg::*;

    localparam int TO = 4;
    localparam int CW = 4;
    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_JAL = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        inst_valid = 1'b1, imem_ready = 1'b0, dmem_ready = 1'b0;
    wb_sel_t     wb_sel = WB_ALU;
    rf_wen_t     rf_wen = RF_NONE;
    mem_wen_t    mem_wen = MEM_NONE;
    pc_sel_t     pc_sel = PC_PLUS4;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, trap;
    logic [1:0]  trap_cause;
    ctrl_state_t state;
`ifdef RISCV_CTRL_PERF_EN
    logic [CW-1:0] cycle_cnt, instret_cnt;
`endif

    riscv_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_inst_valid (inst_valid),
        .i_wb_sel     (wb_sel),
        .i_rf_wen     (rf_wen),
        .i_mem_wen    (mem_wen),
        .i_pc_sel     (pc_sel),
        .i_imem_ready (imem_ready),
        .i_dmem_ready (dmem_ready),
        .o_imem_req   (imem_req),
        .o_dmem_req   (dmem_req),
        .o_dmem_we    (dmem_we),
        .o_ir_we      (ir_we),
        .o_pc_we      (pc_we),
        .o_rf_we      (rf_we),
        .o_retire     (retire),
        .o_trap       (trap),
        .o_trap_cause (trap_cause),
        .o_state      (state)
`ifdef RISCV_CTRL_PERF_EN
        ,
        .o_cycle_cnt  (cycle_cnt),
        .o_instret_cnt(instret_cnt)
`endif
    );

    typedef struct packed {
        logic     ir;
        logic     dr;
        logic     iv;
        wb_sel_t  ws;
        rf_wen_t  rw;
        mem_wen_t mw;
        pc_sel_t  ps;
    } stim_t;

    // strb = {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, trap}
    typedef struct packed {
        logic [7:0]  strb;
        logic [1:0]  cause;
        ctrl_state_t st;
        int          cyc;
        int          ret;
    } exp_t;

    stim_t stim_q[$];
    exp_t  exp_q[$];
    stim_t m_fld;
    int    m_cyc, m_ret;
    logic [1:0] m_cause;

    int n_cmp = 0, n_fail = 0;
    int cur_idx = 0;
    logic cur_valid = 1'b0;

    int obs_ret[$];
    int obs_imem, obs_dmem, obs_dwe, obs_rf, obs_pc;

    // ---------------- model ----------------
    task automatic model_reset();
        stim_q.delete();
        exp_q.delete();
        m_cyc   = 0;
        m_ret   = 0;
        m_cause = TRAP_NONE;
    endtask

    task automatic push(input logic ir, input logic dr, input ctrl_state_t st,
                        input logic [7:0] strb);
        stim_t s;
        exp_t  e;
        s       = m_fld;
        s.ir    = ir;
        s.dr    = dr;
        e.strb  = strb;
        e.cause = strb[0] ? m_cause : TRAP_NONE;
        e.st    = st;
        e.cyc   = m_cyc;
        e.ret   = m_ret;
        stim_q.push_back(s);
        exp_q.push_back(e);
        if (!strb[0]) m_cyc++;
        if (strb[1])  m_ret++;
    endtask

    // wi / wd: number of not-ready cycles before the memory answers.
    task automatic add_instr(input int kind, input int wi, input int wd, input logic valid);
        logic st_op, rfw;
        m_fld.iv = valid;
        case (kind)
            K_LD:    begin m_fld.ws = WB_MEM; m_fld.rw = RF_WRITE; m_fld.mw = MEM_NONE;  m_fld.ps = PC_PLUS4; end
            K_ST:    begin m_fld.ws = WB_ALU; m_fld.rw = RF_NONE;  m_fld.mw = MEM_WRITE; m_fld.ps = PC_PLUS4; end
            K_JAL:   begin m_fld.ws = WB_PC4; m_fld.rw = RF_WRITE; m_fld.mw = MEM_NONE;  m_fld.ps = PC_JAL;   end
            default: begin m_fld.ws = WB_ALU; m_fld.rw = RF_WRITE; m_fld.mw = MEM_NONE;  m_fld.ps = PC_PLUS4; end
        endcase
        st_op = (kind == K_ST);
        rfw   = (kind != K_ST);
        for (int c = 0; c <= wi; c++) begin
            if (c == wi) push(1'b1, 1'b1, S_FETCH, 8'b1001_0000);
            else if (c == TO) begin
                push(1'b0, 1'b1, S_FETCH, 8'b1000_0000);
                m_cause = TRAP_IMEM_TO;
                return;
            end else push(1'b0, 1'b1, S_FETCH, 8'b1000_0000);
        end
        push(1'b1, 1'b1, S_DECODE, 8'b0);
        if (!valid) begin
            m_cause = TRAP_ILLEGAL;
            return;
        end
        push(1'b1, 1'b1, S_EXEC, 8'b0);
        if (kind == K_LD || kind == K_ST) begin
            for (int c = 0; c <= wd; c++) begin
                if (c == wd) push(1'b1, 1'b1, S_MEM, {2'b01, st_op, 5'b0});
                else if (c == TO) begin
                    push(1'b1, 1'b0, S_MEM, {2'b01, st_op, 5'b0});
                    m_cause = TRAP_DMEM_TO;
                    return;
                end else push(1'b1, 1'b0, S_MEM, {2'b01, st_op, 5'b0});
            end
        end
        push(1'b1, 1'b1, S_WB, {4'b0, 1'b1, rfw, 2'b10});
    endtask

    task automatic add_trap(input int n);
        for (int i = 0; i < n; i++) push(1'b1, 1'b1, S_TRAP, 8'b0000_0001);
    endtask

    // ---------------- driver ----------------
    task automatic do_reset();
        cur_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    task automatic drive(input int k);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        imem_ready = stim_q[k].ir;
        dmem_ready = stim_q[k].dr;
        inst_valid = stim_q[k].iv;
        wb_sel     = stim_q[k].ws;
        rf_wen     = stim_q[k].rw;
        mem_wen    = stim_q[k].mw;
        pc_sel     = stim_q[k].ps;
        cur_idx    = k;
        cur_valid  = 1'b1;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) drive(k);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
        cur_valid = 1'b0;
    endtask

    task automatic clear_obs();
        obs_ret.delete();
        obs_imem = 0; obs_dmem = 0; obs_dwe = 0; obs_rf = 0; obs_pc = 0;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, got, want);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    exp_t       ce;
    logic [7:0] act;
    logic       ok;

    always @(negedge clk) begin
        if (cur_valid) begin
            ce  = exp_q[cur_idx];
            act = {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, retire, trap};
            ok  = (act == ce.strb) && (trap_cause == ce.cause) && (state == ce.st);
`ifdef RISCV_CTRL_PERF_EN
            ok  = ok && (cycle_cnt == CW'(ce.cyc)) && (instret_cnt == CW'(ce.ret));
`endif
            n_cmp++;
            if (!ok) begin
                n_fail++;
`ifdef RISCV_CTRL_PERF_EN
                $display("FAIL cycle[%0d]: got strb=%b cause=%0d state=%0d cyc=%0d ret=%0d, want strb=%b cause=%0d state=%0d cyc=%0d ret=%0d",
                         cur_idx, act, trap_cause, state, cycle_cnt, instret_cnt,
                         ce.strb, ce.cause, ce.st, CW'(ce.cyc), CW'(ce.ret));
`else
                $display("FAIL cycle[%0d]: got strb=%b cause=%0d state=%0d, want strb=%b cause=%0d state=%0d",
                         cur_idx, act, trap_cause, state, ce.strb, ce.cause, ce.st);
`endif
            end
            if (retire)   obs_ret.push_back(cur_idx);
            if (imem_req) obs_imem++;
            if (dmem_req) obs_dmem++;
            if (dmem_we)  obs_dwe++;
            if (rf_we)    obs_rf++;
            if (pc_we)    obs_pc++;
        end
    end

    // ---------------- scenarios ----------------
    initial begin
        // Mixed stream: ADDI, LW (3 dmem waits), SW, JAL (2 imem waits)
        model_reset();
        add_instr(K_ALU, 0, 0, 1'b1);
        add_instr(K_LD,  0, 3, 1'b1);
        add_instr(K_ST,  0, 0, 1'b1);
        add_instr(K_JAL, 2, 0, 1'b1);
        do_reset();
        #1;
        check("reset_state", int'(state), int'(S_FETCH));
        check("reset_imem_req", int'(imem_req), 1);
        check("reset_trap", int'({trap, trap_cause}), 0);
`ifdef RISCV_CTRL_PERF_EN
        check("reset_counters", int'({cycle_cnt, instret_cnt}), 0);
`endif
        clear_obs();
        run(stim_q.size());
        settle();
        check("mix_retire_count", obs_ret.size(), 4);
        if (obs_ret.size() == 4) begin
            check("addi_retire_cycle", obs_ret[0], 3);
            check("lw_retire_cycle",   obs_ret[1], 11);
            check("sw_retire_cycle",   obs_ret[2], 16);
            check("jal_retire_cycle",  obs_ret[3], 22);
        end
        check("mix_dmem_req_cycles", obs_dmem, 5);
        check("mix_dmem_we_cycles",  obs_dwe, 1);
        check("mix_rf_we_cycles",    obs_rf, 3);
        check("mix_pc_we_cycles",    obs_pc, 4);

        // Illegal instruction, then reset restarts fetch
        model_reset();
        add_instr(K_ALU, 0, 0, 1'b0);
        add_trap(6);
        do_reset();
        clear_obs();
        run(stim_q.size());
        settle();
        check("illegal_cause", int'(trap_cause), 1);
        check("illegal_imem_req_cycles", obs_imem, 1);
        model_reset();
        add_instr(K_ALU, 0, 0, 1'b1);
        do_reset();
        clear_obs();
        run(stim_q.size());
        settle();
        check("restart_retire_cycle", (obs_ret.size() == 1) ? obs_ret[0] : -1, 3);

        // imem stuck low -> timeout trap
        model_reset();
        add_instr(K_ALU, 99, 0, 1'b1);
        add_trap(4);
        do_reset();
        clear_obs();
        run(stim_q.size());
        settle();
        check("imem_to_cause", int'(trap_cause), 2);
        check("imem_to_req_cycles", obs_imem, 5);

        // imem ready on the compare cycle, then one cycle earlier: no trap
        model_reset();
        add_instr(K_ALU, 4, 0, 1'b1);
        add_instr(K_ALU, 3, 0, 1'b1);
        do_reset();
        clear_obs();
        run(stim_q.size());
        settle();
        check("imem_late_no_trap", int'(trap), 0);
        check("imem_late_retires", (obs_ret.size() == 2) ? obs_ret[1] : -1, 14);

        // dmem stuck low -> timeout trap
        model_reset();
        add_instr(K_LD, 0, 99, 1'b1);
        add_trap(4);
        do_reset();
        run(stim_q.size());
        settle();
        check("dmem_to_cause", int'(trap_cause), 3);

        // dmem ready on the compare cycle: access completes
        model_reset();
        add_instr(K_LD, 0, 4, 1'b1);
        do_reset();
        clear_obs();
        run(stim_q.size());
        settle();
        check("dmem_late_retire_cycle", (obs_ret.size() == 1) ? obs_ret[0] : -1, 8);

        // Reset asserted in the middle of a data access
        model_reset();
        add_instr(K_LD, 0, 99, 1'b1);
        do_reset();
        run(6);
        settle();
        check("midreset_before", int'(dmem_req), 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_req_dropped", int'({imem_req, dmem_req}), 2);

        // 16 back-to-back ADDIs: counter values and wrap
        model_reset();
        for (int i = 0; i < 16; i++) add_instr(K_ALU, 0, 0, 1'b1);
        do_reset();
        for (int k = 0; k < stim_q.size(); k++) begin
            drive(k);
`ifdef RISCV_CTRL_PERF_EN
            if (k == 40) begin
                check("perf_instret_10", int'(instret_cnt), 10);
                check("perf_cycle_40",   int'(cycle_cnt), 40 % 16);
            end
`endif
        end
        settle();
`ifdef RISCV_CTRL_PERF_EN
        check("perf_instret_wrap", int'(instret_cnt), 0);
        check("perf_cycle_wrap",   int'(cycle_cnt), 0);
`endif
        check("perf_no_trap", int'(trap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/riscv_ctrl_fsm.md
# riscv_ctrl_fsm

Multi-cycle control sequencer for the RV32I core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives the enables for the IR, PC, register file and data memory. It takes its per-instruction control fields from `riscv_decoder` and handshakes with the instruction and data memory ports. It also detects illegal instructions and memory-port timeouts and raises a sticky trap.

## Interface
- `MEM_TIMEOUT`, default 255: maximum wait cycles per memory handshake; 0 disables the timeout.
- `CNT_W`, default 32: width of the performance counters.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `inst_valid` in 1: decoder recognised the instruction in IR.
- `wb_sel` in WB_SEL: decoder writeback select.
- `rf_wen` in RF_WEN: decoder register-write control.
- `mem_wen` in MEM_WEN: decoder store control.
- `pc_sel` in PC_SEL: decoder next-PC select.
- `imem_ready` in 1: instruction memory data valid.
- `dmem_ready` in 1: data memory access complete.
- `imem_req` out 1: instruction fetch request.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: data access is a store.
- `ir_we` out 1: latch the fetched word into IR.
- `pc_we` out 1: update PC using `pc_sel`.
- `rf_we` out 1: register file write strobe.
- `retire` out 1: one-cycle pulse per completed instruction.
- `trap` out 1: sticky; set on an error.
- `trap_cause` out 2: 0 none, 1 illegal instruction, 2 imem timeout, 3 dmem timeout.
- `state_o` out CTRL_STATE: current state, for debug.
- `cycle_cnt` out CNT_W: cycle counter. Present only with the configuration macro.
- `instret_cnt` out CNT_W: retired-instruction counter. Present only with the configuration macro.

## Operation
- States: S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP.
- S_FETCH
  - `imem_req`=1.
  - A handshake completes on any cycle with `imem_req` and `imem_ready` both high.
  - On completion: `ir_we` pulses for that cycle and the FSM moves to S_DECODE.
- S_DECODE
  - One cycle with no strobes.
  - If `inst_valid`=0: go to S_TRAP with cause 1. Otherwise go to S_EXEC.
- S_EXEC
  - One cycle for the ALU.
  - Go to S_MEM if `wb_sel`==WB_MEM or `mem_wen`==MEM_WRITE. Otherwise go to S_WB.
- S_MEM
  - `dmem_req`=1; `dmem_we`=1 when `mem_wen`==MEM_WRITE.
  - On `dmem_ready`: go to S_WB.
- S_WB
  - One cycle: `pc_we`=1, `retire`=1, and `rf_we`=1 iff `rf_wen`==RF_WRITE.
  - Then go to S_FETCH.
- Timeout
  - An 8-bit-or-wider wait counter clears on entry to S_FETCH and S_MEM.
  - It increments on each cycle where a request is high and ready is low.
  - When the count equals `MEM_TIMEOUT` (and `MEM_TIMEOUT`≠0), go to S_TRAP with cause 2 (fetch) or 3 (mem).
  - A ready arriving in the same cycle as the timeout compare wins: the access completes and no trap is taken.
- S_TRAP
  - Absorbing state: all strobes are 0 and `trap`=1.
  - `trap_cause` holds its value until `rst`.
- The decoder inputs are treated as stable from S_DECODE through S_WB, because IR changes only on `ir_we`.

## Timing
- Reset values:
  - State is S_FETCH.
  - Every strobe (`imem_req` excepted), `trap`, `trap_cause`, the wait counter and both perf counters are 0.
  - `imem_req` is 1 in the first cycle after reset.
- Strobes are combinational from the state register and inputs. There is no registered output latency.
- With zero wait states:
  - ALU, jump: 4 cycles per instruction (F, D, E, WB).
  - Load, store: 5 cycles per instruction.
- Each wait cycle adds one cycle.
- Reset asserted mid-access: the request drops in the following cycle, the transaction is abandoned, and memory must tolerate it.
- `rst` overrides S_TRAP.

## Configuration
- `RISCV_CTRL_PERF_EN` defined:
  - `cycle_cnt` increments on every non-reset cycle.
  - `instret_cnt` increments on `retire`.
  - Both wrap modulo 2^CNT_W and freeze in S_TRAP.
- `RISCV_CTRL_PERF_EN` undefined: both counters and their ports are absent.

## Structure
- Shared package additions:
  - CTRL_STATE enum.
  - TRAP_CAUSE constants (TRAP_NONE, TRAP_ILLEGAL, TRAP_IMEM_TO, TRAP_DMEM_TO).
- Reused from the package: WB_SEL, RF_WEN, MEM_WEN, PC_SEL.
- Sub-module `riscv_perf_counter` (enable, wrap, freeze), instantiated twice under the macro.

## Test plan
- ADDI with `imem_ready`/`dmem_ready` tied high → `retire` in cycle 4. `rf_we` and `pc_we` pulse only in cycle 4. `dmem_req` never asserted.
- LW with `dmem_ready` delayed 3 cycles → `dmem_req` high for 4 cycles with `dmem_we`=0. `retire` in cycle 8. `rf_we`=1 in WB.
- SW → `dmem_we`=1 in S_MEM. `rf_we`=0 in WB. `retire` in cycle 5.
- `inst_valid`=0 → S_TRAP after S_DECODE with `trap_cause`=1. No further `imem_req`. A later `rst` restarts fetch.
- `MEM_TIMEOUT`=4 with `imem_ready` stuck low → trap with cause 2 after 4 wait cycles. Repeat with ready arriving on the 4th wait cycle → no trap.
- With `RISCV_CTRL_PERF_EN`, 10 ADDIs → `instret_cnt`=10 and `cycle_cnt`=40. `CNT_W`=4 wraps to 0 after 16 instructions.
